imm_packer: RTL

- Encode side of immediate handling: takes an instruction format select, a 32-bit immediate and the non-immediate instruction bits, and produces the 25-bit instr[31:7] field with the immediate scattered into RISC-V I/S/B/U/J positions.
- Range/alignment checks flag any immediate that cannot be represented.
- Used by the instruction-generation / self-test path feeding the fetch side; round-trips bit-exactly with the core's sign-extension unit.
- Two-stage valid/ready pipeline with a saturating error counter.

---
 rtl/imm_packer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/imm_packer.sv
// Encode-side immediate packer: scatters a 32-bit immediate into the RISC-V instr[31:7]
// field for I/S/B/U/J formats, flags unrepresentable values, two-stage valid/ready pipe.
module imm_packer #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_sel,
    input  logic [31:0]          in_imm,
    input  logic [24:0]          in_rest,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [24:0]          out_field,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4
    } fmt_e;

    // True when v[31:msb] are all equal, i.e. v fits as a signed (msb+1)-bit value.
    function automatic logic fits_signed(input logic [31:0] v, input int msb);
        logic [31:0] sh;
        sh = $unsigned($signed(v) >>> msb);
        return (&sh) || !(|sh);
    endfunction

    logic        s1_valid;
    fmt_e        s1_sel;
    logic [31:0] s1_imm;
    logic [24:0] s1_rest;

    logic        s2_load;
    logic [24:0] pack_field;
    logic        pack_err;
    logic        out_xfer;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: payload registers carry no reset; s1_valid alone qualifies them, which keeps
    // the reset fan-out off the wide datapath.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_sel  <= fmt_e'(in_sel);
            s1_imm  <= in_imm;
            s1_rest <= in_rest;
        end
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        pack_field = s1_rest;
        pack_err   = 1'b0;
        case (s1_sel)
            FMT_I: begin
                pack_field[24:13] = s1_imm[11:0];
                pack_err          = !fits_signed(s1_imm, 11);
            end
            FMT_S: begin
                pack_field[24:18] = s1_imm[11:5];
                pack_field[4:0]   = s1_imm[4:0];
                pack_err          = !fits_signed(s1_imm, 11);
            end
            FMT_B: begin
                pack_field[24]    = s1_imm[12];
                pack_field[23:18] = s1_imm[10:5];
                pack_field[4:1]   = s1_imm[4:1];
                pack_field[0]     = s1_imm[11];
                pack_err          = !fits_signed(s1_imm, 12) || s1_imm[0];
            end
            FMT_U: begin
                pack_field[24:5] = s1_imm[31:12];
                pack_err         = |s1_imm[11:0];
            end
            FMT_J: begin
                pack_field[24]    = s1_imm[20];
                pack_field[23:14] = s1_imm[10:1];
                pack_field[13]    = s1_imm[11];
                pack_field[12:5]  = s1_imm[19:12];
                pack_err          = !fits_signed(s1_imm, 20) || s1_imm[0];
            end
            default: begin
                // Illegal selects pass the surrounding bits through untouched.
                pack_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_field <= '0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_field <= pack_field;
                out_err   <= pack_err;
            end
        end
    end

    // Clear beats increment; the counter sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (out_xfer && out_err && !(&err_cnt)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule
